// File: rtl/conv_ddr_pkg.sv
// Shared types and constants for the conv DDR read arbiter slice.
// Requester IDs, FSM encoding and default bus widths.
package conv_ddr_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LEN_W_DEF  = 8;

    localparam logic REQ_INPUT  = 1'b0;
    localparam logic REQ_WEIGHT = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

    // Expand a requester ID into its one-hot strobe position.
    function automatic logic [1:0] req_onehot(input logic id);
        if (id) begin
            return 2'b10;
        end else begin
            return 2'b01;
        end
    endfunction

endpackage

// File: rtl/conv_ddr_read_arbiter_if.sv
// Requester + DDR read channel bundle for conv_ddr_read_arbiter.
// master: arbiter side; slave: loaders/DDR model side.
interface conv_ddr_read_arbiter_if
    import conv_ddr_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int OUT_CNT_W = 3
);
    logic [1:0]           req_valid;
    logic [ADDR_W-1:0]    req_addr0;
    logic [LEN_W-1:0]     req_len0;
    logic [ADDR_W-1:0]    req_addr1;
    logic [LEN_W-1:0]     req_len1;
    logic [1:0]           req_ready;
    logic                 ddr_ar_valid;
    logic [ADDR_W-1:0]    ddr_ar_addr;
    logic [LEN_W-1:0]     ddr_ar_len;
    logic                 ddr_ar_ready;
    logic                 ddr_r_valid;
    logic                 ddr_r_last;
    logic [1:0]           rsp_valid;
    logic                 rsp_last;
    logic [OUT_CNT_W-1:0] outstanding;
    logic                 rsp_error;

    modport master (
        input  req_valid, req_addr0, req_len0, req_addr1, req_len1,
        input  ddr_ar_ready, ddr_r_valid, ddr_r_last,
        output req_ready, ddr_ar_valid, ddr_ar_addr, ddr_ar_len,
        output rsp_valid, rsp_last, outstanding, rsp_error
    );

    modport slave (
        output req_valid, req_addr0, req_len0, req_addr1, req_len1,
        output ddr_ar_ready, ddr_r_valid, ddr_r_last,
        input  req_ready, ddr_ar_valid, ddr_ar_addr, ddr_ar_len,
        input  rsp_valid, rsp_last, outstanding, rsp_error
    );

endinterface

// File: rtl/conv_rd_id_fifo.sv
// In-order 1-bit ID FIFO recording which requester owns each burst in flight.
// Pointers carry an extra wrap bit so full/empty and count need no extra state.
module conv_rd_id_fifo #(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        din,
    output logic        head,
    output logic        empty,
    output logic        full,
    output logic [AW:0] count
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [DEPTH-1:0] mem_q;
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;

    // Pointer advance; a simultaneous push and pop moves both.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/conv_ddr_read_arbiter.sv
// Two-requester DDR read arbiter: issues one AR at a time, routes R beats in order.
// Define CONV_RD_ARB_INPUT_PRIO_EN for fixed input-tile priority instead of round-robin.
module conv_ddr_read_arbiter
    import conv_ddr_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int LEN_W           = LEN_W_DEF,
    parameter int MAX_OUTSTANDING = 4,
    parameter int OUT_CNT_W       = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    conv_ddr_read_arbiter_if.master bus
);

    arb_state_e           state_q;
    logic                 id_q;
    logic [ADDR_W-1:0]    ar_addr_q;
    logic [LEN_W-1:0]     ar_len_q;
    logic                 rsp_error_q;
    logic                 rsp_error_d;
`ifndef CONV_RD_ARB_INPUT_PRIO_EN
    logic                 ptr_q;
`endif

    logic                 grant_s;
    logic                 accept_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 fifo_head_s;
    logic                 fifo_empty_s;
    logic                 fifo_full_s;
    logic [OUT_CNT_W-1:0] fifo_count_s;
    logic [1:0]           rsp_valid_s;

    // Grant selection for the requester set presented in IDLE.
    always_comb begin
        grant_s = REQ_INPUT;
`ifdef CONV_RD_ARB_INPUT_PRIO_EN
        if (bus.req_valid[0]) begin
            grant_s = REQ_INPUT;
        end else begin
            grant_s = REQ_WEIGHT;
        end
`else
        if (bus.req_valid == 2'b11) begin
            grant_s = ptr_q;
        end else if (bus.req_valid[0]) begin
            grant_s = REQ_INPUT;
        end else begin
            grant_s = REQ_WEIGHT;
        end
`endif
    end

    // Count is sampled before any same-cycle pop, so a freed slot is usable next cycle.
    assign accept_s = (state_q == IDLE) && (bus.req_valid != 2'b00) &&
                      (fifo_count_s < OUT_CNT_W'(MAX_OUTSTANDING));
    assign push_s   = (state_q == ISSUE) && bus.ddr_ar_ready && !fifo_full_s;
    assign pop_s    = bus.ddr_r_valid && bus.ddr_r_last && !fifo_empty_s;

    // Issue FSM: latch the granted descriptor, hold it until the AR handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            id_q      <= REQ_INPUT;
            ar_addr_q <= '0;
            ar_len_q  <= '0;
`ifndef CONV_RD_ARB_INPUT_PRIO_EN
            ptr_q     <= REQ_INPUT;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        state_q   <= ISSUE;
                        id_q      <= grant_s;
                        ar_addr_q <= grant_s ? bus.req_addr1 : bus.req_addr0;
                        ar_len_q  <= grant_s ? bus.req_len1 : bus.req_len0;
                    end
                end
                ISSUE: begin
                    if (bus.ddr_ar_ready) begin
                        state_q <= IDLE;
`ifndef CONV_RD_ARB_INPUT_PRIO_EN
                        ptr_q   <= ~id_q;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_error_d = rsp_error_q | (bus.ddr_r_valid & fifo_empty_s);

    // Sticky flag for beats arriving with nothing in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_error_q <= 1'b0;
        end else begin
            rsp_error_q <= rsp_error_d;
        end
    end

    // Zero-latency beat routing to the owner at the FIFO head.
    always_comb begin
        rsp_valid_s = 2'b00;
        if (bus.ddr_r_valid && !fifo_empty_s) begin
            rsp_valid_s = req_onehot(fifo_head_s);
        end else begin
            rsp_valid_s = 2'b00;
        end
    end

    conv_rd_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (id_q),
        .head  (fifo_head_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s),
        .count (fifo_count_s)
    );

    assign bus.req_ready    = accept_s ? req_onehot(grant_s) : 2'b00;
    assign bus.ddr_ar_valid = (state_q == ISSUE);
    assign bus.ddr_ar_addr  = ar_addr_q;
    assign bus.ddr_ar_len   = ar_len_q;
    assign bus.rsp_valid    = rsp_valid_s;
    assign bus.rsp_last     = bus.ddr_r_last;
    assign bus.outstanding  = fifo_count_s;
    assign bus.rsp_error    = rsp_error_q;

endmodule

// File: tb/tb_conv_ddr_read_arbiter.sv
// Self-checking bench for conv_ddr_read_arbiter with a scoreboard of issued
// descriptors and in-flight owner IDs; honours CONV_RD_ARB_INPUT_PRIO_EN.
module tb_conv_ddr_read_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [31:0] exp_addr_q[$];
    logic [7:0]  exp_len_q[$];
    logic        id_fifo_q[$];
    logic        mptr;

    conv_ddr_read_arbiter_if #(.ADDR_W(32), .LEN_W(8), .OUT_CNT_W(3)) bus ();

    conv_ddr_read_arbiter #(
        .ADDR_W(32), .LEN_W(8), .MAX_OUTSTANDING(4), .OUT_CNT_W(3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_grant(input logic [1:0] rv, input logic p);
`ifdef CONV_RD_ARB_INPUT_PRIO_EN
        return rv[0] ? 1'b0 : 1'b1;
`else
        if (rv == 2'b11) return p;
        return rv[0] ? 1'b0 : 1'b1;
`endif
    endfunction

    function automatic logic [1:0] oh(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req_valid = 2'b00;
        bus.ddr_ar_ready = 1'b0;
        bus.ddr_r_valid = 1'b0;
        bus.ddr_r_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_addr_q.delete();
        exp_len_q.delete();
        id_fifo_q.delete();
        mptr = 1'b0;
    endtask

    // Drives one accept + handshake pair; only updates the model.
    task automatic issue_burst(input logic [1:0] rv);
        logic g;
        g = model_grant(rv, mptr);
        bus.req_valid = rv;
        bus.ddr_ar_ready = 1'b0;
        next_cycle();
        bus.req_valid = 2'b00;
        bus.ddr_ar_ready = 1'b1;
        next_cycle();
        bus.ddr_ar_ready = 1'b0;
        id_fifo_q.push_back(g);
`ifndef CONV_RD_ARB_INPUT_PRIO_EN
        mptr = ~g;
`endif
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready); end
        checks++; if (bus.ddr_ar_valid !== 1'b0) begin errors++; $display("FAIL reset_ar_valid got=%b exp=0", bus.ddr_ar_valid); end
        checks++; if (bus.ddr_ar_addr !== 32'h0) begin errors++; $display("FAIL reset_ar_addr got=%h exp=0", bus.ddr_ar_addr); end
        checks++; if (bus.ddr_ar_len !== 8'h0) begin errors++; $display("FAIL reset_ar_len got=%h exp=0", bus.ddr_ar_len); end
        checks++; if (bus.outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding got=%0d exp=0", bus.outstanding); end
        checks++; if (bus.rsp_error !== 1'b0) begin errors++; $display("FAIL reset_rsp_error got=%b exp=0", bus.rsp_error); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic g;
        logic [31:0] ea;
        logic [7:0]  el;
        do_reset();
        bus.req_addr0 = 32'h1000_0000; bus.req_len0 = 8'd3;
        bus.req_addr1 = 32'h2000_0000; bus.req_len1 = 8'd7;
        bus.req_valid = 2'b11;
        bus.ddr_ar_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            g = model_grant(2'b11, mptr);
            checks++; if (bus.req_ready !== oh(g)) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", b, bus.req_ready, oh(g)); end
            checks++; if (bus.ddr_ar_valid !== 1'b0) begin errors++; $display("FAIL rr_ar_idle%0d got=%b exp=0", b, bus.ddr_ar_valid); end
            exp_addr_q.push_back(g ? bus.req_addr1 : bus.req_addr0);
            exp_len_q.push_back(g ? bus.req_len1 : bus.req_len0);
            next_cycle();
            // Move the request fields to prove the issued descriptor was latched.
            bus.req_addr0 = bus.req_addr0 + 32'h40;
            bus.req_addr1 = bus.req_addr1 + 32'h80;
            bus.req_len0 = bus.req_len0 + 8'd1;
            @(negedge clk);
            ea = exp_addr_q.pop_front();
            el = exp_len_q.pop_front();
            checks++; if (bus.ddr_ar_valid !== 1'b1) begin errors++; $display("FAIL rr_ar_valid%0d got=%b exp=1", b, bus.ddr_ar_valid); end
            checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL rr_ready_issue%0d got=%b exp=00", b, bus.req_ready); end
            checks++; if (bus.ddr_ar_addr !== ea) begin errors++; $display("FAIL rr_addr%0d got=%h exp=%h", b, bus.ddr_ar_addr, ea); end
            checks++; if (bus.ddr_ar_len !== el) begin errors++; $display("FAIL rr_len%0d got=%h exp=%h", b, bus.ddr_ar_len, el); end
            id_fifo_q.push_back(g);
`ifndef CONV_RD_ARB_INPUT_PRIO_EN
            mptr = ~g;
`endif
            next_cycle();
        end
    endtask

    // Continues from test_round_robin with four bursts in flight.
    task automatic test_stall();
        logic g;
        logic [31:0] ea;
        @(negedge clk);
        checks++; if (bus.outstanding !== 3'd4) begin errors++; $display("FAIL stall_out4 got=%0d exp=4", bus.outstanding); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus.req_ready !== 2'b00 || bus.ddr_ar_valid !== 1'b0) begin errors++; $display("FAIL stall_hold%0d ready=%b arv=%b exp=00/0", c, bus.req_ready, bus.ddr_ar_valid); end
            next_cycle();
            @(negedge clk);
        end
        next_cycle();
        bus.ddr_r_valid = 1'b1;
        bus.ddr_r_last = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL stall_pop_same_cycle got=%b exp=00", bus.req_ready); end
        checks++; if (bus.rsp_valid !== oh(id_fifo_q[0])) begin errors++; $display("FAIL stall_rsp got=%b exp=%b", bus.rsp_valid, oh(id_fifo_q[0])); end
        void'(id_fifo_q.pop_front());
        next_cycle();
        bus.ddr_r_valid = 1'b0;
        bus.ddr_r_last = 1'b0;
        @(negedge clk);
        g = model_grant(2'b11, mptr);
        checks++; if (bus.outstanding !== 3'd3) begin errors++; $display("FAIL stall_out3 got=%0d exp=3", bus.outstanding); end
        checks++; if (bus.req_ready !== oh(g)) begin errors++; $display("FAIL stall_regrant got=%b exp=%b", bus.req_ready, oh(g)); end
        ea = g ? bus.req_addr1 : bus.req_addr0;
        next_cycle();
        @(negedge clk);
        checks++; if (bus.ddr_ar_addr !== ea) begin errors++; $display("FAIL stall_regrant_addr got=%h exp=%h", bus.ddr_ar_addr, ea); end
        next_cycle();
        bus.req_valid = 2'b00;
        bus.ddr_ar_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.outstanding !== 3'd4) begin errors++; $display("FAIL stall_refill got=%0d exp=4", bus.outstanding); end
        next_cycle();
    endtask

    task automatic test_response_routing();
        logic [1:0] ev;
        do_reset();
        bus.req_addr0 = 32'h0000_A000; bus.req_len0 = 8'd3;
        bus.req_addr1 = 32'h0000_B000; bus.req_len1 = 8'd1;
        issue_burst(2'b01);
        issue_burst(2'b10);
        @(negedge clk);
        checks++; if (bus.outstanding !== 3'd2) begin errors++; $display("FAIL resp_out2 got=%0d exp=2", bus.outstanding); end
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL resp_idle got=%b exp=00", bus.rsp_valid); end
        next_cycle();
        for (int k = 0; k < 6; k++) begin
            bus.ddr_r_valid = 1'b1;
            bus.ddr_r_last = (k == 3) || (k == 5);
            @(negedge clk);
            ev = oh(id_fifo_q[0]);
            checks++; if (bus.rsp_valid !== ev) begin errors++; $display("FAIL resp_beat%0d got=%b exp=%b", k, bus.rsp_valid, ev); end
            checks++; if (bus.rsp_last !== bus.ddr_r_last) begin errors++; $display("FAIL resp_last%0d got=%b exp=%b", k, bus.rsp_last, bus.ddr_r_last); end
            if (bus.ddr_r_last) void'(id_fifo_q.pop_front());
            next_cycle();
        end
        bus.ddr_r_valid = 1'b0;
        bus.ddr_r_last = 1'b0;
        @(negedge clk);
        checks++; if (bus.outstanding !== 3'd0 || bus.rsp_error !== 1'b0) begin errors++; $display("FAIL resp_drained out=%0d err=%b exp=0/0", bus.outstanding, bus.rsp_error); end
        next_cycle();
    endtask

    task automatic test_push_pop_same_cycle();
        logic [1:0] ev;
        do_reset();
        issue_burst(2'b01);
        issue_burst(2'b10);
        bus.req_valid = 2'b01;
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL pp_accept got=%b exp=01", bus.req_ready); end
        next_cycle();
        bus.req_valid = 2'b00;
        bus.ddr_ar_ready = 1'b1;
        bus.ddr_r_valid = 1'b1;
        bus.ddr_r_last = 1'b1;
        @(negedge clk);
        ev = oh(id_fifo_q[0]);
        checks++; if (bus.rsp_valid !== ev) begin errors++; $display("FAIL pp_old_head got=%b exp=%b", bus.rsp_valid, ev); end
        void'(id_fifo_q.pop_front());
        id_fifo_q.push_back(1'b0);
        next_cycle();
        bus.ddr_ar_ready = 1'b0;
        bus.ddr_r_valid = 1'b0;
        bus.ddr_r_last = 1'b0;
        @(negedge clk);
        checks++; if (bus.outstanding !== 3'd2) begin errors++; $display("FAIL pp_out2 got=%0d exp=2", bus.outstanding); end
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            bus.ddr_r_valid = 1'b1;
            bus.ddr_r_last = 1'b1;
            @(negedge clk);
            ev = oh(id_fifo_q[0]);
            checks++; if (bus.rsp_valid !== ev) begin errors++; $display("FAIL pp_head%0d got=%b exp=%b", k, bus.rsp_valid, ev); end
            void'(id_fifo_q.pop_front());
            next_cycle();
        end
        bus.ddr_r_valid = 1'b0;
        bus.ddr_r_last = 1'b0;
        @(negedge clk);
        checks++; if (bus.outstanding !== 3'd0) begin errors++; $display("FAIL pp_out0 got=%0d exp=0", bus.outstanding); end
        next_cycle();
    endtask

    task automatic test_orphan_beat();
        do_reset();
        issue_burst(2'b01);
        do_reset();
        bus.ddr_r_valid = 1'b1;
        bus.ddr_r_last = 1'b1;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL orphan_rsp got=%b exp=00", bus.rsp_valid); end
        checks++; if (bus.rsp_error !== 1'b0) begin errors++; $display("FAIL orphan_err_early got=%b exp=0", bus.rsp_error); end
        next_cycle();
        bus.ddr_r_valid = 1'b0;
        bus.ddr_r_last = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.rsp_error !== 1'b1) begin errors++; $display("FAIL orphan_sticky%0d got=%b exp=1", c, bus.rsp_error); end
            checks++; if (bus.outstanding !== 3'd0) begin errors++; $display("FAIL orphan_out%0d got=%0d exp=0", c, bus.outstanding); end
            next_cycle();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mptr = 1'b0;
        reset = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_addr0 = 32'h0;
        bus.req_len0 = 8'h0;
        bus.req_addr1 = 32'h0;
        bus.req_len1 = 8'h0;
        bus.ddr_ar_ready = 1'b0;
        bus.ddr_r_valid = 1'b0;
        bus.ddr_r_last = 1'b0;
        test_reset();
        test_round_robin();
        test_stall();
        test_response_routing();
        test_push_pop_same_cycle();
        test_orphan_beat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
